pidx_seq: RTL and testbench



---
 rtl/pidx_seq_pkg.sv | 27 ++
 rtl/pidx_seq_if.sv | 36 +++
 rtl/pidx_seq.sv | 147 ++++++++++++++
 tb/tb_pidx_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pidx_seq_pkg.sv
// pidx_pkg: shared definitions for the pidx sequencer and its datapath sibling.
//   PIDX_BSW : log2 of byte lanes per beat
//   PIDX_BS  : byte lanes per beat
//   PIDX_WW  : element length width (max length 2^WW-1 < BS)
//   state_e  : sequencer states
//   beat_t   : one beat descriptor as seen by pidx
package pidx_pkg;

    localparam int PIDX_BSW = 5;
    localparam int PIDX_BS  = 1 << PIDX_BSW;
    localparam int PIDX_WW  = 9 - PIDX_BSW;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [PIDX_BSW:0]                  inum;
        logic [PIDX_BS-1:0][PIDX_WW-1:0]    ilen;
        logic [PIDX_BS-1:0][PIDX_BSW-1:0]   ipos;
        logic [PIDX_BS-1:0][PIDX_BSW:0]     psum;
        logic [PIDX_BSW:0]                  bytes;
        logic                               last;
    } beat_t;

endpackage

// File: rtl/pidx_seq_if.sv
// pidx_seq_if: element-descriptor input stream and beat-descriptor output
// stream of the pidx sequencer.
//   in_valid/in_ready/in_len/in_last : one element length per accepted cycle
//   out_valid/out_ready              : beat handshake
//   out_inum/ilen/ipos/psum/bytes/last : beat descriptor fields
// Modports: slave = sequencer side, master = element source / beat consumer.
interface pidx_seq_if;
    import pidx_pkg::*;

    logic                               in_valid;
    logic                               in_ready;
    logic [PIDX_WW-1:0]                 in_len;
    logic                               in_last;

    logic                               out_valid;
    logic                               out_ready;
    logic [PIDX_BSW:0]                  out_inum;
    logic [PIDX_BS-1:0][PIDX_WW-1:0]    out_ilen;
    logic [PIDX_BS-1:0][PIDX_BSW-1:0]   out_ipos;
    logic [PIDX_BS-1:0][PIDX_BSW:0]     out_psum;
    logic [PIDX_BSW:0]                  out_bytes;
    logic                               out_last;

    modport slave (
        input  in_valid, in_len, in_last, out_ready,
        output in_ready, out_valid, out_inum, out_ilen, out_ipos,
               out_psum, out_bytes, out_last
    );

    modport master (
        output in_valid, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_inum, out_ilen, out_ipos,
               out_psum, out_bytes, out_last
    );

endinterface

// File: rtl/pidx_seq.sv
// pidx_seq: packs a stream of variable-length elements into beats of BS byte
// lanes and emits one packing descriptor per beat for the pidx datapath.
// An element straddling a beat boundary is split; its remainder opens the
// next beat at slot 0.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : pidx_seq_if.slave (element input stream, beat output stream)
module pidx_seq
    import pidx_pkg::*;
#(
    parameter int VLEN = 256,
    parameter int BSW  = PIDX_BSW
) (
    input  logic        clk,
    input  logic        rst,
    pidx_seq_if.slave   bus
);

    localparam int BS = 1 << BSW;
    localparam int WW = 9 - BSW;
    localparam logic [BSW:0] BS_W = (BSW+1)'(BS);

    localparam logic [0:0] FILL = ST_FILL;
    localparam logic [0:0] EMIT = ST_EMIT;

    // The interface and beat_t are sized by the package, so the instance
    // must agree with it; BSW >= 5 guarantees a carry fits in one beat.
    if (BSW < 5 || BSW != PIDX_BSW) begin : g_bad_bsw
        $error("pidx_seq: BSW must be >= 5 and equal pidx_pkg::PIDX_BSW");
    end
    if (VLEN != 8 * BS) begin : g_bad_vlen
        $error("pidx_seq: VLEN must equal 8*BS");
    end

    logic [0:0]                 state;
    logic [BSW:0]               count;
    logic [BSW:0]               fill;
    logic [BS-1:0][WW-1:0]      ilen_r;
    logic [BS-1:0][BSW-1:0]     ipos_r;
    logic [BS-1:0][BSW:0]       psum_r;
    logic                       carry_vld;
    logic [WW-1:0]              carry_len;
    logic [BSW-1:0]             carry_pos;
    logic                       carry_last;
    logic                       last_pend;

    logic [BSW:0]               len_x;
    logic [BSW:0]               room;
    logic [BSW:0]               take;
    logic                       split;
    logic [BSW-1:0]             slot;

    // take = min(len, room); split when the element overruns the beat.
    always_comb begin
        len_x = (BSW+1)'(bus.in_len);
        room  = BS_W - fill;
        split = len_x > room;
        take  = split ? room : len_x;
        // count < BS whenever FILL is active, so the low bits index the slot
        slot  = count[BSW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            count      <= '0;
            fill       <= '0;
            ilen_r     <= '0;
            ipos_r     <= '0;
            psum_r     <= '0;
            carry_vld  <= 1'b0;
            carry_len  <= '0;
            carry_pos  <= '0;
            carry_last <= 1'b0;
            last_pend  <= 1'b0;
        end else if (state == FILL) begin
            if (bus.in_valid) begin
                // zero-length non-last elements occupy no slot
                if (len_x != '0) begin
                    ilen_r[slot] <= take[WW-1:0];
                    ipos_r[slot] <= '0;
                    psum_r[slot] <= fill + take;
                    count        <= count + 1'b1;
                    fill         <= fill + take;
                    if (split) begin
                        carry_vld  <= 1'b1;
                        carry_len  <= bus.in_len - take[WW-1:0];
                        carry_pos  <= take[BSW-1:0];
                        carry_last <= bus.in_last;
                        state      <= EMIT;
                    end else if (fill + take == BS_W || count == BS_W - 1'b1) begin
                        state <= EMIT;
                    end
                end
                if (bus.in_last) begin
                    last_pend <= 1'b1;
                    state     <= EMIT;
                end
            end
        end else if (bus.out_ready) begin
            ilen_r <= '0;
            ipos_r <= '0;
            psum_r <= '0;
            count  <= '0;
            fill   <= '0;
            if (carry_vld) begin
                // remainder of the split element opens the next beat
                ilen_r[0] <= carry_len;
                ipos_r[0] <= carry_pos;
                psum_r[0] <= (BSW+1)'(carry_len);
                count     <= (BSW+1)'(1);
                fill      <= (BSW+1)'(carry_len);
                carry_vld <= 1'b0;
                last_pend <= carry_last;
                // a frame-final carry is emitted on its own without new input
                if (!carry_last) begin
                    state <= FILL;
                end
            end else begin
                last_pend <= 1'b0;
                state     <= FILL;
            end
        end
    end

    beat_t beat;

    always_comb begin
        beat.inum  = count;
        beat.ilen  = ilen_r;
        beat.ipos  = ipos_r;
        beat.psum  = psum_r;
        beat.bytes = fill;
        // a pending carry means the frame still has one more beat
        beat.last  = last_pend && !carry_vld;
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_inum  = beat.inum;
    assign bus.out_ilen  = beat.ilen;
    assign bus.out_ipos  = beat.ipos;
    assign bus.out_psum  = beat.psum;
    assign bus.out_bytes = beat.bytes;
    assign bus.out_last  = beat.last;

endmodule

// File: tb/tb_pidx_seq.sv
// tb_pidx_seq: directed self-checking bench for pidx_seq (BS=32, WW=4).
module tb_pidx_seq;
    import pidx_pkg::*;

    localparam int BSW = PIDX_BSW;
    localparam int BS  = PIDX_BS;
    localparam int WW  = PIDX_WW;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    logic [BS-1:0][WW-1:0]  e_ilen;
    logic [BS-1:0][BSW-1:0] e_ipos;
    logic [BS-1:0][BSW:0]   e_psum;

    pidx_seq_if bus ();

    pidx_seq #(.VLEN(256), .BSW(BSW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int len, input bit last);
        int t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_len   = WW'(len);
        bus.in_last  = last;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_len   = '0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pop();
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL pop_timeout: out_valid=%0b required 1", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_len = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: valid=%0b ready=%0b required 0 1", bus.out_valid, bus.in_ready);
        end
        n_chk++;
        if (bus.out_inum !== '0 || bus.out_bytes !== '0 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_scalars: inum=%0d bytes=%0d last=%0b required 0 0 0",
                     bus.out_inum, bus.out_bytes, bus.out_last);
        end
        n_chk++;
        if (bus.out_ilen !== '0 || bus.out_ipos !== '0 || bus.out_psum !== '0) begin
            n_fail++;
            $display("FAIL reset_arrays: ilen=%h ipos=%h psum=%h required 0",
                     bus.out_ilen, bus.out_ipos, bus.out_psum);
        end
    endtask

    task automatic test_one_beat();
        send(10, 0); send(10, 0);
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL one_beat_open: valid=%0b ready=%0b required 0 1", bus.out_valid, bus.in_ready);
        end
        send(12, 0);
        @(negedge clk);
        e_ilen = '0; e_ilen[0] = 10; e_ilen[1] = 10; e_ilen[2] = 12;
        e_psum = '0; e_psum[0] = 10; e_psum[1] = 20; e_psum[2] = 32;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL one_beat_hs: valid=%0b ready=%0b required 1 0", bus.out_valid, bus.in_ready);
        end
        n_chk++;
        if (bus.out_inum !== 6'd3 || bus.out_bytes !== 6'd32 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL one_beat_scalars: inum=%0d bytes=%0d last=%0b required 3 32 0",
                     bus.out_inum, bus.out_bytes, bus.out_last);
        end
        n_chk++;
        if (bus.out_ilen !== e_ilen || bus.out_psum !== e_psum || bus.out_ipos !== '0) begin
            n_fail++;
            $display("FAIL one_beat_arrays: ilen=%h psum=%h ipos=%h required ilen=%h psum=%h ipos=0",
                     bus.out_ilen, bus.out_psum, bus.out_ipos, e_ilen, e_psum);
        end
        pop();
    endtask

    task automatic test_carry();
        send(10, 0); send(10, 0); send(15, 0);
        @(negedge clk);
        e_ilen = '0; e_ilen[0] = 10; e_ilen[1] = 10; e_ilen[2] = 12;
        e_psum = '0; e_psum[0] = 10; e_psum[1] = 20; e_psum[2] = 32;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0 || bus.out_ilen !== e_ilen || bus.out_psum !== e_psum) begin
            n_fail++;
            $display("FAIL carry_beat1: valid=%0b last=%0b ilen=%h psum=%h required 1 0 ilen=%h psum=%h",
                     bus.out_valid, bus.out_last, bus.out_ilen, bus.out_psum, e_ilen, e_psum);
        end
        pop();
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_bytes !== 6'd3) begin
            n_fail++;
            $display("FAIL carry_refill: valid=%0b ready=%0b bytes=%0d required 0 1 3",
                     bus.out_valid, bus.in_ready, bus.out_bytes);
        end
        send(5, 0); send(5, 0); send(0, 1);
        @(negedge clk);
        e_ilen = '0; e_ilen[0] = 3;  e_ilen[1] = 5; e_ilen[2] = 5;
        e_psum = '0; e_psum[0] = 3;  e_psum[1] = 8; e_psum[2] = 13;
        e_ipos = '0; e_ipos[0] = 12;
        n_chk++;
        if (bus.out_inum !== 6'd3 || bus.out_bytes !== 6'd13 || bus.out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_beat2_scalars: inum=%0d bytes=%0d last=%0b required 3 13 1",
                     bus.out_inum, bus.out_bytes, bus.out_last);
        end
        n_chk++;
        if (bus.out_ilen !== e_ilen || bus.out_psum !== e_psum || bus.out_ipos !== e_ipos) begin
            n_fail++;
            $display("FAIL carry_beat2_arrays: ilen=%h psum=%h ipos=%h required ilen=%h psum=%h ipos=%h",
                     bus.out_ilen, bus.out_psum, bus.out_ipos, e_ilen, e_psum, e_ipos);
        end
        pop();
    endtask

    task automatic test_fill_ones();
        for (int i = 0; i < BS; i++) send(1, 0);
        @(negedge clk);
        e_ilen = '0; e_psum = '0;
        for (int k = 0; k < BS; k++) begin
            e_ilen[k] = WW'(1);
            e_psum[k] = (BSW+1)'(k + 1);
        end
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_inum !== 6'd32 || bus.out_bytes !== 6'd32 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_scalars: valid=%0b inum=%0d bytes=%0d last=%0b required 1 32 32 0",
                     bus.out_valid, bus.out_inum, bus.out_bytes, bus.out_last);
        end
        n_chk++;
        if (bus.out_ilen !== e_ilen || bus.out_psum !== e_psum) begin
            n_fail++;
            $display("FAIL ones_arrays: ilen=%h psum=%h required ilen=%h psum=%h",
                     bus.out_ilen, bus.out_psum, e_ilen, e_psum);
        end
        pop();
    endtask

    task automatic test_last_carry();
        send(15, 0); send(15, 0); send(15, 1);
        @(negedge clk);
        e_ilen = '0; e_ilen[0] = 15; e_ilen[1] = 15; e_ilen[2] = 2;
        e_psum = '0; e_psum[0] = 15; e_psum[1] = 30; e_psum[2] = 32;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0 || bus.out_ilen !== e_ilen ||
            bus.out_psum !== e_psum || bus.out_ipos !== '0) begin
            n_fail++;
            $display("FAIL lastc_beat1: valid=%0b last=%0b ilen=%h psum=%h ipos=%h required 1 0 ilen=%h psum=%h ipos=0",
                     bus.out_valid, bus.out_last, bus.out_ilen, bus.out_psum, bus.out_ipos, e_ilen, e_psum);
        end
        pop();
        @(negedge clk);
        e_ilen = '0; e_ilen[0] = 13;
        e_psum = '0; e_psum[0] = 13;
        e_ipos = '0; e_ipos[0] = 2;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_inum !== 6'd1 ||
            bus.out_bytes !== 6'd13 || bus.out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL lastc_beat2_scalars: valid=%0b ready=%0b inum=%0d bytes=%0d last=%0b required 1 0 1 13 1",
                     bus.out_valid, bus.in_ready, bus.out_inum, bus.out_bytes, bus.out_last);
        end
        n_chk++;
        if (bus.out_ilen !== e_ilen || bus.out_psum !== e_psum || bus.out_ipos !== e_ipos) begin
            n_fail++;
            $display("FAIL lastc_beat2_arrays: ilen=%h psum=%h ipos=%h required ilen=%h psum=%h ipos=%h",
                     bus.out_ilen, bus.out_psum, bus.out_ipos, e_ilen, e_psum, e_ipos);
        end
        pop();
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_bytes !== '0) begin
            n_fail++;
            $display("FAIL lastc_done: valid=%0b ready=%0b bytes=%0d required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_bytes);
        end
    endtask

    task automatic test_back_pressure();
        send(10, 0); send(10, 0); send(12, 0);
        e_ilen = '0; e_ilen[0] = 10; e_ilen[1] = 10; e_ilen[2] = 12;
        e_psum = '0; e_psum[0] = 10; e_psum[1] = 20; e_psum[2] = 32;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_inum !== 6'd3 ||
                bus.out_bytes !== 6'd32 || bus.out_ilen !== e_ilen || bus.out_psum !== e_psum) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b inum=%0d bytes=%0d psum=%h required 1 0 3 32 psum=%h",
                         i, bus.out_valid, bus.in_ready, bus.out_inum, bus.out_bytes, bus.out_psum, e_psum);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%0b ready=%0b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_zero_len();
        send(0, 0);
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inum !== '0) begin
            n_fail++;
            $display("FAIL zero_drop: valid=%0b ready=%0b inum=%0d required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_inum);
        end
        send(0, 1);
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_inum !== '0 || bus.out_bytes !== '0 ||
            bus.out_last !== 1'b1 || bus.out_psum !== '0) begin
            n_fail++;
            $display("FAIL zero_last: valid=%0b inum=%0d bytes=%0d last=%0b required 1 0 0 1",
                     bus.out_valid, bus.out_inum, bus.out_bytes, bus.out_last);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        send(10, 0); send(10, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inum !== '0 ||
            bus.out_bytes !== '0 || bus.out_psum !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: valid=%0b ready=%0b inum=%0d bytes=%0d required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.out_inum, bus.out_bytes);
        end
        send(4, 1);
        @(negedge clk);
        e_ilen = '0; e_ilen[0] = 4;
        e_psum = '0; e_psum[0] = 4;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_inum !== 6'd1 || bus.out_bytes !== 6'd4 ||
            bus.out_last !== 1'b1 || bus.out_psum !== e_psum || bus.out_ilen !== e_ilen) begin
            n_fail++;
            $display("FAIL rstmid_beat: valid=%0b inum=%0d bytes=%0d last=%0b psum=%h required 1 1 4 1 psum=%h",
                     bus.out_valid, bus.out_inum, bus.out_bytes, bus.out_last, bus.out_psum, e_psum);
        end
        pop();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_one_beat();
        test_carry();
        test_fill_ones();
        test_last_carry();
        test_back_pressure();
        test_zero_len();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
